// File: rtl/pcw_loader_pkg.sv
// Shared types and constants for the ioctl download loader.
package pcw_loader_pkg;

  // Loader control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    EXEC  = 2'd3
  } loader_state_t;

  // One buffered download byte with its target address.
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } loader_entry_t;

  // ioctl_wait asserts this many entries short of full, leaving room for
  // the byte hps_io may still deliver after it sees wait rise.
  localparam int WAIT_OFFSET = 2;

endpackage

// File: rtl/pcw_ioctl_loader_if.sv
// Bus bundle between hps_io (ioctl side) and pcw_core (dn_*/execute side).
// Handshake: ioctl_wr is a one-cycle strobe, a byte is taken when ioctl_wr,
// ioctl_download and a matching ioctl_index are all high on a clock edge;
// ioctl_wait is the only back-pressure and the source may deliver one more
// strobe after it rises. dn_wr is a one-cycle strobe the core must accept.
interface pcw_ioctl_loader_if;
  import pcw_loader_pkg::*;

  logic          ioctl_download;
  logic          ioctl_wr;
  logic [15:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic [7:0]    ioctl_index;
  logic          ioctl_wait;
  logic          dn_go;
  logic          dn_wr;
  logic [15:0]   dn_addr;
  logic [7:0]    dn_data;
  logic [15:0]   execute_addr;
  logic          execute_enable;
  logic          overflow;
  logic [16:0]   bytes_written;
  loader_state_t dbg_state;

  // Environment side: drives the download stream, observes the core port.
  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  ioctl_wait, dn_go, dn_wr, dn_addr, dn_data, execute_addr,
    input  execute_enable, overflow, bytes_written, dbg_state
  );

  // Loader side.
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output ioctl_wait, dn_go, dn_wr, dn_addr, dn_data, execute_addr,
    output execute_enable, overflow, bytes_written, dbg_state
  );
endinterface

// File: rtl/pcw_loader_fifo.sv
// First-word-fall-through FIFO of address/data entries. Pushes while full
// and pops while empty are ignored, so contents never get corrupted.
module pcw_loader_fifo
  import pcw_loader_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  loader_entry_t          i_din,
  output loader_entry_t          o_dout,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);

  loader_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage array; no reset needed since pointers gate every read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/pcw_ioctl_loader.sv
// Buffers the hps_io ioctl byte stream and replays it as paced dn_wr writes
// into pcw_core RAM, then pulses execute_enable once the image is in place.
module pcw_ioctl_loader
  import pcw_loader_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int          WR_GAP     = 2,
  parameter logic [7:0]  LOAD_INDEX = 8'd0,
  parameter logic [15:0] EXEC_ADDR  = 16'h0000
) (
  input  logic               i_clk_sys,
  input  logic               i_reset_n,
  pcw_ioctl_loader_if.slave  io_bus
);
  localparam int             CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  WAIT_LEVEL = CW'(FIFO_DEPTH - WAIT_OFFSET);

  loader_state_t r_state;
  loader_state_t w_next;
  loader_entry_t w_din;
  loader_entry_t w_dout;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_next;
  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_push_ok;
  logic          w_pop;
  logic          w_load_start;
  logic [7:0]    r_gap;
  logic          r_wait;
  logic          r_dn_go;
  logic          r_dn_wr;
  logic [15:0]   r_dn_addr;
  logic [7:0]    r_dn_data;
  logic          r_exec;
  logic          r_overflow;
  logic [16:0]   r_bytes;

  assign w_accept     = io_bus.ioctl_wr && io_bus.ioctl_download &&
                        (io_bus.ioctl_index == LOAD_INDEX);
  assign w_push_ok    = w_accept && !w_full;
  assign w_din.addr   = io_bus.ioctl_addr;
  assign w_din.data   = io_bus.ioctl_dout;
  assign w_count_next = w_count + CW'(w_push_ok) - CW'(w_pop);

  pcw_loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk     (i_clk_sys),
    .i_reset_n (i_reset_n),
    .i_push    (w_accept),
    .i_pop     (w_pop),
    .i_din     (w_din),
    .o_dout    (w_dout),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Next state, pop decision and load-start detection.
  always_comb begin
    w_next       = r_state;
    w_pop        = 1'b0;
    w_load_start = 1'b0;
    case (r_state)
      IDLE: begin
        // A leftover entry (byte taken during EXEC) also restarts a load.
        if (w_accept || !w_empty) begin
          w_next       = LOAD;
          w_load_start = 1'b1;
        end
      end
      LOAD: begin
        w_pop = !w_empty && (r_gap == 8'd0);
        if (!io_bus.ioctl_download) w_next = FLUSH;
      end
      FLUSH: begin
        w_pop = !w_empty && (r_gap == 8'd0);
        if (w_accept)                          w_next = LOAD;
        else if (w_empty && (r_gap == 8'd0))   w_next = EXEC;
      end
      EXEC: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register, write pacing and all registered outputs.
  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_gap      <= 8'd0;
      r_wait     <= 1'b0;
      r_dn_go    <= 1'b0;
      r_dn_wr    <= 1'b0;
      r_dn_addr  <= 16'h0000;
      r_dn_data  <= 8'h00;
      r_exec     <= 1'b0;
      r_overflow <= 1'b0;
      r_bytes    <= 17'd0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_count_next >= WAIT_LEVEL);
      r_dn_wr <= w_pop;
      r_exec  <= (w_next == EXEC);
      if (w_pop) begin
        r_dn_addr <= w_dout.addr;
        r_dn_data <= w_dout.data;
        r_gap     <= 8'(WR_GAP);
      end else if (r_gap != 8'd0) begin
        r_gap <= r_gap - 8'd1;
      end
      if (w_load_start)          r_dn_go <= 1'b1;
      else if (w_next == EXEC)   r_dn_go <= 1'b0;
      if (w_load_start)             r_overflow <= 1'b0;
      else if (w_accept && w_full)  r_overflow <= 1'b1;
      if (w_load_start)                          r_bytes <= 17'd0;
      else if (w_pop && (r_bytes != 17'h1FFFF))  r_bytes <= r_bytes + 17'd1;
    end
  end

  assign io_bus.ioctl_wait     = r_wait;
  assign io_bus.dn_go          = r_dn_go;
  assign io_bus.dn_wr          = r_dn_wr;
  assign io_bus.dn_addr        = r_dn_addr;
  assign io_bus.dn_data        = r_dn_data;
  assign io_bus.execute_addr   = EXEC_ADDR;
  assign io_bus.execute_enable = r_exec;
  assign io_bus.overflow       = r_overflow;
  assign io_bus.bytes_written  = r_bytes;
  assign io_bus.dbg_state      = r_state;
endmodule

// File: doc/pcw_ioctl_loader.md
Name: pcw_ioctl_loader

Overview:
- Bridges the hps_io ioctl download stream (ROM/boot image, selected by ioctl_index) onto the pcw_core dn_* memory write port.
- Buffers bytes in a small FIFO, throttles hps_io with ioctl_wait, and paces writes into core RAM.
- Pulses execute_enable once the last byte has landed, so the core starts the loaded image.
- Sits between hps_io and pcw_core's dn_go/dn_wr/dn_addr/dn_data/execute_* inputs.

Parameters:
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 4.
- WR_GAP, 2, minimum idle cycles between dn_wr pulses (0 allows back-to-back writes).
- LOAD_INDEX, 8'd0, ioctl_index value this loader accepts.
- EXEC_ADDR, 16'h0000, value driven on execute_addr at the execute pulse.

Ports:
- clk_sys  in  1  system clock (32 MHz).
- reset_n  in  1  synchronous, active-low reset.
- ioctl_download  in  1  download in progress (from hps_io).
- ioctl_wr  in  1  byte strobe, one cycle.
- ioctl_addr  in  16  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  image index.
- ioctl_wait  out  1  back-pressure to hps_io.
- dn_go  out  1  load window active.
- dn_wr  out  1  one-cycle write strobe to core.
- dn_addr  out  16  write address.
- dn_data  out  8  write data.
- execute_addr  out  16  start address.
- execute_enable  out  1  one-cycle start pulse.
- overflow  out  1  sticky; a byte was dropped.
- bytes_written  out  17  count of dn_wr pulses in the current load.

Behaviour:
- Reset (reset_n=0 at a clk_sys edge):
  - FIFO emptied, state IDLE.
  - Every output is 0; execute_addr=EXEC_ADDR.
  - A reset mid-load aborts the load: no further dn_wr and no execute pulse.
- Accept: ioctl_wr && ioctl_download && ioctl_index==LOAD_INDEX pushes {ioctl_addr, ioctl_dout}. Strobes with any other index are ignored.
- ioctl_wait is registered, 1 while FIFO count >= FIFO_DEPTH-2. This absorbs the one extra byte hps_io may deliver after wait rises.
- Push while full: byte dropped, overflow=1 until reset_n or the next load start. FIFO contents are unchanged.
- Simultaneous push and pop: count unchanged; both take effect.
- FSM states:
  - IDLE → LOAD on the first accepted byte. Same cycle: dn_go set, overflow cleared, bytes_written cleared.
  - LOAD: pop when FIFO is non-empty and gap counter==0.
    - The pop drives dn_wr=1 for one cycle with dn_addr/dn_data registered from the popped entry. Pop to dn_wr is 1 cycle.
    - dn_addr/dn_data hold their values until the next pop.
    - The gap counter reloads to WR_GAP; bytes_written increments, saturating at 17'h1FFFF.
    - LOAD → FLUSH when ioctl_download falls.
  - FLUSH: keeps draining with the same pacing.
    - A new accepted byte (download restarted) returns the FSM to LOAD without clearing counters.
    - When the FIFO is empty and the gap counter==0 → EXEC.
  - EXEC: execute_enable=1 for exactly one cycle, dn_go←0 the same cycle, then → IDLE.
- Zero-length download (ioctl_download pulses with no accepted byte): stays IDLE, no dn_go, no execute pulse.
- dn_go timing: rises no later than 1 cycle before the first dn_wr. Falls with the execute pulse, after the last dn_wr.
- Address wrap: ioctl_addr passes through unmodified; 16'hFFFF followed by 16'h0000 is legal.

Decomposition:
- Package pcw_loader_pkg:
  - loader_state_t enum: IDLE, LOAD, FLUSH, EXEC.
  - loader_entry_t packed struct: addr[15:0], data[7:0].
  - Localparam for the ioctl_wait threshold offset (2).
- Sub-module pcw_loader_fifo: synchronous FIFO of loader_entry_t, parameter DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - First-word-fall-through; reset_n active-low synchronous.

Test Plan:
- Index 0, 4 bytes at addrs 0..3 (data A5,5A,FF,00), WR_GAP=2:
  - 4 dn_wr pulses, each ≥3 cycles apart, with matching addr/data.
  - bytes_written=4.
  - One execute_enable pulse with execute_addr=0000 after the download falls; dn_go low afterwards.
- Burst of 16 bytes on consecutive cycles, FIFO_DEPTH=8, hps_io honouring ioctl_wait with 1-cycle lag:
  - ioctl_wait rises at count 6; no overflow.
  - All 16 bytes written in order.
- Force 10 back-to-back strobes ignoring ioctl_wait: overflow=1; exactly the FIFO-accepted bytes are written in order, no duplicates.
- Strobes with ioctl_index=1: no dn_go, no dn_wr, no execute pulse.
- reset_n low for 1 cycle after 3 of 8 bytes written: dn_wr stops; outputs reset; no execute_enable within 100 cycles.
- Addrs FFFE, FFFF, 0000: dn_addr sequence FFFE, FFFF, 0000; bytes_written=3.
